// File: rtl/sram_burst_reader.sv
// sram_burst_reader: streams LENGTH consecutive words out of a synchronous
// SRAM read port with 1-cycle read latency onto a valid/ready stream.
// The read address wraps from the top of the address space back to 0.
// A 2-entry output buffer absorbs backpressure. Reads are only issued when
// buffer space is already reserved for them, so no returning word is lost.
// Optional feature: define SRAM_BURST_READER_ABORT_EN to add an abort input.
// Abort flushes a running burst and returns the block to idle without done.
module sram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cen,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
`ifdef SRAM_BURST_READER_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  state_t                          state_q, state_d;
  logic                            done_d;
  logic [ADDR_WIDTH-1:0]           rd_ptr;     // next word to read
  logic [ADDR_WIDTH-1:0]           addr_q;     // last address issued
  logic [ADDR_WIDTH:0]             issue_cnt;  // reads still to issue
  logic [ADDR_WIDTH:0]             xfer_cnt;   // words still to hand over
  logic [1:0]                      occ;        // buffer occupancy, 0..2
  logic                            inflight;   // read issued last cycle
  logic [1:0][DATA_WIDTH-1:0]      buf_q;      // [0] is the stream head
  logic                            active;
  logic                            abort_w;
  logic                            accept;
  logic                            issue;
  logic                            cap;
  logic                            pop;
  logic [2:0]                      committed;

  assign active = (state_q != IDLE);
  assign accept = (state_q == IDLE) && start && (length != '0);

`ifdef SRAM_BURST_READER_ABORT_EN
  // Abort only matters while a burst is running. In idle, start proceeds.
  assign abort_w = abort && active;
`else
  assign abort_w = 1'b0;
`endif

  assign out_valid = (occ != 2'd0);
  assign out_data  = buf_q[0];
  assign pop       = out_valid && out_ready;
  // The word returning from the RAM this cycle is dropped on abort.
  assign cap       = inflight && !abort_w;
  assign busy      = active;

  // Buffer entries left after this cycle's pop, plus the read already in
  // flight. A new read may only be issued if its landing slot is free even
  // when the consumer stalls from now on. A full buffer never issues, even
  // when it is popping this cycle.
  assign committed = {1'b0, occ} - {2'b00, pop} + {2'b00, inflight};
  assign issue     = active && !abort_w && (issue_cnt != '0) &&
                     (occ != 2'd2) && (committed < 3'd2);

  // The RAM address is presented only on issue. Otherwise it holds the last value.
  assign ram_cen  = issue;
  assign ram_addr = issue ? rd_ptr : addr_q;

  // Next-state and done-pulse decode
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) done_d  = 1'b1;
          else              state_d = RUN;
        end
      end
      RUN: begin
        if (issue && (issue_cnt == CNT_ONE)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && (xfer_cnt == CNT_ONE)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_w) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  // State register and registered done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
    end
  end

  // Burst bookkeeping: read pointer, issue/transfer counts, held address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      addr_q    <= '0;
      issue_cnt <= '0;
      xfer_cnt  <= '0;
    end else if (accept) begin
      rd_ptr    <= base_addr;
      issue_cnt <= length;
      xfer_cnt  <= length;
    end else if (abort_w) begin
      issue_cnt <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (issue) begin
        rd_ptr    <= rd_ptr + ADDR_ONE;  // wraps naturally at the top
        addr_q    <= rd_ptr;
        issue_cnt <= issue_cnt - CNT_ONE;
      end
      if (pop) xfer_cnt <= xfer_cnt - CNT_ONE;
    end
  end

  // Output buffer: capture returning RAM data, shift on pop, flush on abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      buf_q    <= '0;
    end else if (abort_w) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      case ({cap, pop})
        2'b10: begin
          // The issue rule guarantees occ < 2 here.
          buf_q[occ[0]] <= ram_q;
          occ           <= occ + 2'd1;
        end
        2'b01: begin
          buf_q[0] <= buf_q[1];
          occ      <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf_q[0] <= ram_q;
          end else begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_reader.sv
// Bench for sram_burst_reader. It uses a behavioural RAM with 1-cycle read
// latency. An expected-word queue model is checked every cycle. Directed
// bursts carry literal expectations for data, timing and done/busy.
module tb_sram_burst_reader;
  localparam int DW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          out_ready = 1'b0;
  logic          busy, done, ram_cen, out_valid;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q, out_data;
`ifdef SRAM_BURST_READER_ABORT_EN
  logic          abort = 1'b0;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int cyc = 0;
  int cmp = 0;
  int err = 0;

  logic [7:0] got[$];
  int         got_cyc[$];
  int         done_log[$];

  sram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .ram_addr(ram_addr),
    .ram_cen(ram_cen), .ram_q(ram_q), .out_data(out_data),
    .out_valid(out_valid),
`ifdef SRAM_BURST_READER_ABORT_EN
    .abort(abort),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Synchronous RAM: it keeps reading whatever address is presented.
  always @(posedge clk) ram_q <= mem[ram_addr];

  task automatic check(input string nm, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: bursts are queues of words, plus issue/delivery counts.
  logic [7:0]    exp_q[$];
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  int            m_len = 0;
  int            m_iss = 0;
  int            m_del = 0;
  logic          m_prev_cen = 1'b0;
  logic [AW-1:0] m_addr = '0;

  initial begin
    logic nd;
    logic aborting;
    int   held;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cen", int'(ram_cen), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_addr", int'(ram_addr), 0);
        exp_q.delete();
        m_busy = 1'b0; m_done = 1'b0; m_len = 0; m_iss = 0; m_del = 0;
        m_prev_cen = 1'b0;
      end else begin
        nd = 1'b0;
        check("busy", int'(busy), int'(m_busy));
        check("done", int'(done), int'(m_done));
        if (done) done_log.push_back(cyc);
        if (out_valid) check("valid_expected", int'(exp_q.size() > 0), 1);
        held = m_iss - m_del - int'(m_prev_cen);
        if (ram_cen) begin
          check("cen_allowed", int'(m_busy && (m_iss < m_len)), 1);
          check("cen_held_lt2", int'(held < 2), 1);
          check("ram_addr", int'(ram_addr), int'(m_addr));
          m_addr = m_addr + 10'd1;
          m_iss++;
        end
        if (out_valid && out_ready && exp_q.size() > 0) begin
          check("out_data", int'(out_data), int'(exp_q[0]));
          void'(exp_q.pop_front());
          got.push_back(out_data);
          got_cyc.push_back(cyc);
          m_del++;
        end
        if (ram_cen) check("outstanding", int'((m_iss - m_del) <= 2), 1);
        m_prev_cen = ram_cen;
        aborting = 1'b0;
`ifdef SRAM_BURST_READER_ABORT_EN
        aborting = abort && m_busy;
`endif
        if (aborting) begin
          exp_q.delete();
          m_busy = 1'b0;
        end else if (m_busy && (m_del == m_len)) begin
          m_busy = 1'b0;
          nd = 1'b1;
        end else if (!m_busy && start) begin
          if (length == '0) nd = 1'b1;
          else begin
            m_busy = 1'b1;
            m_len = int'(length);
            m_iss = 0;
            m_del = 0;
            m_addr = base_addr;
            for (int i = 0; i < m_len; i++)
              exp_q.push_back(mem[(int'(base_addr) + i) % (1 << AW)]);
          end
        end
        m_done = nd;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got.delete();
    got_cyc.delete();
    done_log.delete();
  endtask

  task automatic do_start(input int b, input int l, output int sc);
    base_addr = b[AW-1:0];
    length = l[AW:0];
    start = 1'b1;
    sc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n0;
    int k;
    n0 = done_log.size();
    k = 0;
    while (done_log.size() == n0 && k < 400) begin
      tick();
      k++;
    end
    if (done_log.size() == n0) check({nm, "_timeout"}, 0, 1);
    tick();
  endtask

  task automatic check_seq(input string nm, input logic [7:0] e[$]);
    check({nm, "_count"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++)
      check($sformatf("%s_w%0d", nm, i), int'(got[i]), int'(e[i]));
  endtask

  initial begin
    int sc;
    int sc2;
    int k;
    logic [3:0] pat;
    logic [7:0] e[$];

    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i ^ 'h5a);
    mem[16] = 8'hA0; mem[17] = 8'hA1; mem[18] = 8'hA2; mem[19] = 8'hA3;
    mem[10'h3FE] = 8'h11; mem[10'h3FF] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
    for (int i = 0; i < 8; i++) mem[32 + i] = 8'h50 + 8'(i);
    for (int i = 0; i < 6; i++) mem[48 + i] = 8'hC0 + 8'(i);

    // reset
    repeat (3) tick();
    check("init_busy", int'(busy), 0);
    check("init_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // basic burst: 4 words, first valid 3 cycles after start
    clear_logs();
    do_start(16, 4, sc);
    check("t1_busy_after_start", int'(busy), 1);
    check("t1_first_cen", int'(ram_cen), 1);
    check("t1_first_addr", int'(ram_addr), 16);
    wait_done("t1");
    e = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    check_seq("t1", e);
    if (got_cyc.size() == 4) begin
      check("t1_first_valid_cyc", got_cyc[0], sc + 3);
      check("t1_last_valid_cyc", got_cyc[3], sc + 6);
    end
    check("t1_done_count", done_log.size(), 1);
    if (done_log.size() > 0) check("t1_done_cyc", done_log[0], sc + 7);
    check("t1_busy_end", int'(busy), 0);

    // wrap across the top of the address space
    clear_logs();
    do_start(10'h3FE, 4, sc);
    wait_done("t2");
    e = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_seq("t2", e);
    check("t2_done_count", done_log.size(), 1);

    // backpressure: ready pattern 1,0,0,1
    clear_logs();
    do_start(32, 8, sc);
    pat = 4'b1001;
    k = 0;
    while (done_log.size() == 0 && k < 400) begin
      out_ready = pat[k % 4];
      tick();
      k++;
    end
    if (done_log.size() == 0) check("t3_timeout", 0, 1);
    out_ready = 1'b1;
    tick();
    e = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    check_seq("t3", e);
    check("t3_done_count", done_log.size(), 1);

    // zero length: done next cycle, never busy
    clear_logs();
    do_start(16, 0, sc);
    check("t4_len0_done", int'(done), 1);
    check("t4_len0_busy", int'(busy), 0);
    check("t4_len0_valid", int'(out_valid), 0);
    tick();
    check("t4_len0_done_once", int'(done), 0);
    repeat (3) tick();
    check("t4_len0_no_valid", int'(out_valid), 0);
    check("t4_len0_done_count", done_log.size(), 1);

    // start while busy is ignored
    clear_logs();
    do_start(16, 4, sc);
    tick();
    do_start(10'h3FE, 2, sc2);
    wait_done("t4b");
    repeat (5) tick();
    e = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    check_seq("t4b", e);
    check("t4b_done_count", done_log.size(), 1);
    check("t4b_idle", int'(busy), 0);

    // asynchronous reset after 3 of 8 words
    clear_logs();
    do_start(32, 8, sc);
    k = 0;
    while (got.size() < 3 && k < 100) begin
      tick();
      k++;
    end
    if (got.size() < 3) check("t5_timeout", 0, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_cen", int'(ram_cen), 0);
    check("t5_rst_valid", int'(out_valid), 0);
    check("t5_rst_data", int'(out_data), 0);
    check("t5_rst_addr", int'(ram_addr), 0);
    check("t5_words_before_rst", got.size(), 3);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    do_start(16, 4, sc);
    wait_done("t5b");
    e = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    check_seq("t5b", e);
    if (got_cyc.size() > 0) check("t5b_first_valid_cyc", got_cyc[0], sc + 3);

`ifdef SRAM_BURST_READER_ABORT_EN
    // abort after 2 of 6 words
    clear_logs();
    do_start(48, 6, sc);
    k = 0;
    while (got.size() < 2 && k < 100) begin
      tick();
      k++;
    end
    if (got.size() < 2) check("t6_timeout", 0, 1);
    abort = 1'b1;
    out_ready = 1'b0;
    tick();
    abort = 1'b0;
    out_ready = 1'b1;
    check("t6_valid_after_abort", int'(out_valid), 0);
    check("t6_busy_after_abort", int'(busy), 0);
    check("t6_done_after_abort", int'(done), 0);
    repeat (4) tick();
    check("t6_no_done", done_log.size(), 0);
    e = '{8'hC0, 8'hC1};
    check_seq("t6", e);
    clear_logs();
    do_start(0, 2, sc);
    wait_done("t6b");
    e = '{8'h33, 8'h44};
    check_seq("t6b", e);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d words expected completion", got.size());
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_burst_reader.md
Name: sram_burst_reader

Overview:
- Read-side master for a synchronous single- or dual-port SRAM port with 1-cycle registered read latency. Output Q is valid the cycle after the address is presented and is updated every clock.
- On a start command it streams LENGTH consecutive words from a base address, with wrap-around at the top of the address space, onto a valid/ready output stream.
- Typical use: a line-buffer/palette scan-out reader feeding video or a DMA engine while the other RAM port is written by the CPU or sprite engine.

Parameters:
- DATA_WIDTH, 8: RAM word width.
- ADDR_WIDTH, 10: RAM address width; address space is 2**ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe; honoured only while busy=0.
- base_addr  in  ADDR_WIDTH  first word address, sampled on an accepted start.
- length  in  ADDR_WIDTH+1  word count, sampled on an accepted start; 0 means no transfer; max 2**ADDR_WIDTH.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last word is accepted downstream.
- ram_addr  out  ADDR_WIDTH  read address to the RAM port.
- ram_cen  out  1  read-issue qualifier; high in cycles where ram_addr is a real read.
- ram_q  in  DATA_WIDTH  RAM read data, 1-cycle latency after ram_addr.
- out_data  out  DATA_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; a transfer occurs when out_valid and out_ready are both high.

Behaviour:
- Reset values: busy=0, done=0, ram_addr=0, ram_cen=0, out_valid=0, out_data=0. Internal counters and buffer are empty.
- States:
  - IDLE → RUN on start with length≠0. Latch base_addr into rd_ptr, length into issue_cnt and xfer_cnt.
  - start with length=0 gives a done pulse the next cycle; the block stays IDLE and busy stays 0.
  - RUN → DRAIN when issue_cnt reaches 0.
  - DRAIN → IDLE when xfer_cnt reaches 0. done pulses in the cycle after the final transfer, concurrent with the return to IDLE.
- Read issue:
  - Internal 2-entry output buffer.
  - Issue a read (ram_cen=1, ram_addr=rd_ptr) only when occupancy + in-flight < 2 and issue_cnt > 0.
  - At most 1 read is in flight.
  - Each issue: rd_ptr increments modulo 2**ADDR_WIDTH (wraps 2**ADDR_WIDTH-1 → 0); issue_cnt decrements.
- Capture: in the cycle after an issue, ram_q is written into the buffer. Data is never lost under any out_ready pattern, because the issue rule reserves buffer space.
- Output:
  - out_valid is high whenever the buffer is non-empty. out_data is the buffer head, registered with no combinational path from ram_q.
  - Simultaneous capture and pop in the same cycle is legal; occupancy is unchanged.
- Throughput: with out_ready held high, one word per clock after the pipeline fills. The first out_valid appears 3 cycles after the start cycle (start → issue → capture → valid).
- Latency to first read: ram_cen first asserts the cycle after the accepted start.
- start while busy=1 is ignored; there is no queueing.
- Asynchronous reset mid-burst returns everything to reset values immediately. The RAM contents are unaffected.
- ram_addr holds its last value when ram_cen=0. The RAM keeps reading that address, and the resulting data is discarded.

Optional Feature:
- Macro SRAM_BURST_READER_ABORT_EN.
- With the macro: adds input port abort (1 bit). When abort is high in RUN or DRAIN:
  - the buffer and in-flight read are flushed, out_valid=0 next cycle;
  - any capture due that cycle is dropped;
  - the state returns to IDLE; done is NOT pulsed; busy=0 next cycle.
  - abort in IDLE has no effect. abort wins over simultaneous start.
- Without the macro: no abort port exists, and bursts always run to completion.

Test Plan:
- Preload RAM[0x10..0x13]=A0,A1,A2,A3; start base=0x10 length=4, out_ready=1 → out stream A0,A1,A2,A3 on 4 consecutive cycles; first valid at start+3; done pulses once; busy low after.
- Wrap case (ADDR_WIDTH=10): base=0x3FE, length=4, RAM[0x3FE]=11, [0x3FF]=22, [0x000]=33, [0x001]=44 → output 11,22,33,44.
- Backpressure: length=8, out_ready toggling 1,0,0,1 repeating → all 8 words delivered in order with no duplicates or drops; ram_cen never asserts with 2 entries held.
- length=0 start → no out_valid; done pulses the next cycle; busy stays 0. start while busy → ignored, and the first burst completes unchanged.
- Reset: assert rst_n=0 after 3 of 8 words transferred → all outputs at reset values the same cycle; a fresh start after release works normally.
- With SRAM_BURST_READER_ABORT_EN: abort after 2 of 6 words transferred → out_valid=0 next cycle, no done, busy=0; a following start base=0 length=2 delivers RAM[0],RAM[1].
